// File: rtl/e203_itcm_ifu_slv.sv
// ICB responder for the IFU fetch port of the ITCM: one outstanding read, 1-cycle SRAM latency, holdup tracking.
// Optional per-byte even parity checking is enabled by defining E203_ITCM_PARITY_EN.
module e203_itcm_ifu_slv #(
  parameter int AW         = 16,
  parameter int DW         = 64,
  parameter int ITCM_BYTES = 65536
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icb_cmd_valid,
  output logic            icb_cmd_ready,
  input  logic [AW-1:0]   icb_cmd_addr,
  output logic            icb_rsp_valid,
  input  logic            icb_rsp_ready,
  output logic            icb_rsp_err,
  output logic [DW-1:0]   icb_rsp_rdata,
  output logic            holdup,
  output logic            sram_cs,
  output logic [AW-4:0]   sram_addr,
  input  logic [DW-1:0]   sram_dout,
  input  logic            ext_cs,
  output logic            itcm_active
`ifdef E203_ITCM_PARITY_EN
  ,
  input  logic [DW/8-1:0] sram_par
`endif
);

  localparam logic [32:0] LIMIT = 33'(ITCM_BYTES);

  logic          pend;
  logic          first;
  logic          err_q;
  logic          par_q;
  logic          hold_q;
  logic [DW-1:0] rdat_q;

  logic          accept;
  logic          rsp_hs;
  logic          in_range;
  logic          par_bad_now;

  assign in_range      = (33'(icb_cmd_addr) < LIMIT);
  assign rsp_hs        = pend & icb_rsp_ready;
  assign icb_cmd_ready = ~pend | rsp_hs;
  assign accept        = icb_cmd_valid & icb_cmd_ready;

  assign sram_cs       = accept & in_range;
  assign sram_addr     = icb_cmd_addr[AW-1:3];
  assign itcm_active   = pend | icb_cmd_valid;

`ifdef E203_ITCM_PARITY_EN
  logic [DW/8-1:0] byte_bad;

  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    byte_bad = '0;
    for (int i = 0; i < DW/8; i++) begin
      byte_bad[i] = (^sram_dout[8*i +: 8]) ^ sram_par[i];
    end
  end

  assign par_bad_now = |byte_bad;
`else
  assign par_bad_now = 1'b0;
`endif

  // In the first response cycle the SRAM drives the data directly; afterwards the captured copy
  // is used, since another master may overwrite the SRAM output while the response is stalled.
  assign icb_rsp_valid = pend;
  assign icb_rsp_err   = pend & (err_q | (first ? par_bad_now : par_q));
  assign icb_rsp_rdata = err_q ? '0 : (first ? sram_dout : rdat_q);
  assign holdup        = hold_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= 1'b0;
      first  <= 1'b0;
      err_q  <= 1'b0;
      par_q  <= 1'b0;
      hold_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      if (accept) begin
        pend  <= 1'b1;
        err_q <= ~in_range;
      end else if (rsp_hs) begin
        pend  <= 1'b0;
      end
      first <= accept;

      if (first) begin
        rdat_q <= sram_dout;
        par_q  <= par_bad_now;
      end

      // A new IFU read re-establishes the line; a foreign access, an error fetch or bad parity loses it.
      if (ext_cs || (accept && !in_range)) begin
        hold_q <= 1'b0;
      end else if (sram_cs) begin
        hold_q <= 1'b1;
      end else if (first && par_bad_now && !err_q) begin
        hold_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/e203_itcm_ifu_slv.md
Name: e203_itcm_ifu_slv

Overview:
- ICB responder for the IFU instruction-fetch port of the ITCM. It is the target end of the fetch ICB link (cmd addr, then rsp with err/rdata).
- Accepts read-only fetch commands and drives a single-port, 1-cycle-latency ITCM SRAM.
- Returns one response per command, in order, at full throughput.
- Generates the holdup indication the fetch unit uses to skip re-reads of an unchanged SRAM output line.

Parameters:
- AW, 16, ITCM byte-address width; SRAM word address is addr[AW-1:3].
- DW, 64, SRAM/rsp data width (fixed 64 in this revision).
- ITCM_BYTES, 65536, mapped size; commands at addr >= ITCM_BYTES are errors.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- icb_cmd_valid  in  1  fetch command valid
- icb_cmd_ready  out  1  command accepted when valid & ready
- icb_cmd_addr  in  AW  byte address (low 3 bits ignored)
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  IFU accepts response
- icb_rsp_err  out  1  out-of-range (or parity) error
- icb_rsp_rdata  out  DW  fetched line
- holdup  out  1  SRAM output still holds the last IFU-read line
- sram_cs  out  1  SRAM access this cycle
- sram_addr  out  AW-3  SRAM word address
- sram_dout  in  DW  SRAM read data, valid cycle after cs, held until next cs
- ext_cs  in  1  another master (LSU/ext) accessed the SRAM this cycle
- itcm_active  out  1  clock-gate request: pend | icb_cmd_valid

Behaviour:
- Reset values: icb_cmd_ready=1, icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, holdup=0, sram_cs=0, itcm_active=0. All internal flops (pend, first, err_q, rdat_q, hold_q) reset to 0.
- Handshake:
  - icb_cmd_ready = ~pend | (icb_rsp_ready & icb_rsp_valid).
  - A command is accepted in cycle N when valid & ready. At most one response is outstanding.
  - Back-to-back accepts give one response per cycle.
- SRAM access:
  - sram_cs = accept & in_range, combinational in cycle N.
  - sram_addr = icb_cmd_addr[AW-1:3].
  - Out-of-range accept issues no SRAM access.
- Response:
  - pend sets at N+1; first=1 for exactly the first pend cycle.
  - icb_rsp_valid = pend. Latency is 1 cycle, with no bubble.
  - icb_rsp_rdata = first ? sram_dout : rdat_q.
  - rdat_q captures sram_dout when first is 1. This protects data if ext_cs overwrites the SRAM output while the response is stalled.
  - Error responses: icb_rsp_err=1 and rdata forced to 0.
- pend update:
  - pend clears on rsp handshake without a new accept.
  - Rsp handshake together with a new accept in the same cycle keeps pend=1 and sets first=1.
- holdup:
  - Sets at N+1 after an in-range IFU SRAM read.
  - Clears on any ext_cs, on an error accept, and on reset.
  - An IFU read in the same cycle as ext_cs is impossible; the external arbiter guarantees mutual exclusion. Bench asserts ~(sram_cs & ext_cs).
- Reset mid-operation: pend and the response are dropped immediately (asynchronous). No response is issued after reset deasserts.
- Stall: while pend & ~icb_rsp_ready, rsp_valid/err/rdata stay stable cycle to cycle, and no new cs is issued.

Optional Feature:
- Macro: E203_ITCM_PARITY_EN.
- When defined:
  - Adds port sram_par (in, DW/8): even parity per byte, same timing as sram_dout.
  - Parity is checked in the first cycle and registered with rdat_q.
  - Any byte mismatch sets icb_rsp_err=1. rdata is still returned, not zeroed.
  - A parity error also clears holdup.
- When undefined: no sram_par port; err reflects range only.

Test Plan:
- Reset then single fetch:
  - Stimulus: rst pulse; cmd addr=0x0010, sram_dout=0x1122334455667788.
  - Required: sram_cs=1 with sram_addr=0x002 in cycle N; rsp_valid=1, err=0, rdata=0x1122334455667788 in N+1; holdup=1 from N+1.
- Back-to-back:
  - Stimulus: cmd at 0x0, 0x8, 0x10 on consecutive cycles, rsp_ready=1.
  - Required: cmd_ready stays 1; three responses on consecutive cycles, in order.
- Backpressure plus ext overwrite:
  - Stimulus: fetch 0x20 returns 0xAA..AA; rsp_ready=0 for 3 cycles; ext_cs=1 in stall cycle 2 changes sram_dout to 0x55..55.
  - Required: rdata stays 0xAA..AA throughout; cmd_ready=0 while stalled; holdup drops after ext_cs.
- Out of range:
  - Stimulus: cmd addr=0x10000 with AW=17, ITCM_BYTES=65536.
  - Required: no sram_cs; rsp err=1, rdata=0; holdup=0.
- Async reset mid-stall:
  - Stimulus: rst asserted while pend=1 and rsp_ready=0.
  - Required: rsp_valid=0 and cmd_ready=1 immediately; no stale response after release.
- Parity, with E203_ITCM_PARITY_EN:
  - Stimulus: corrupt byte 3 parity.
  - Required: err=1, rdata unchanged, holdup=0.
